// File: rtl/fde_pkg.sv
// Shared fetch/decode/execute definitions: opcodes, pipeline widths, fetch FSM states.
package fde_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned IF_ID_W = 64;
    localparam int unsigned ID_EX_W = 176;

    localparam logic [5:0] OP_HLT = 6'b001101;
    localparam logic [5:0] OP_NOP = 6'b001110;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h3800_0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    // True when the instruction word carries the halt opcode
    function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
        return instr[31:26] == OP_HLT;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: pipeline control in, imem write port in, IF/ID and status out.
interface fetch_unit_if #(
    parameter int unsigned IMEM_DEPTH = 64
);
    import fde_pkg::*;

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               imem_wr_en;
    logic [AW-1:0]      imem_wr_addr;
    logic [INSTR_W-1:0] imem_wr_data;
    logic [IF_ID_W-1:0] if_id;
    logic               halted;
    logic [COUNT_W-1:0] fetch_count;

    // Pipeline/loader side
    modport master (
        output stall, redirect, redirect_pc,
        output imem_wr_en, imem_wr_addr, imem_wr_data,
        input  if_id, halted, fetch_count
    );

    // Fetch unit side
    modport slave (
        input  stall, redirect, redirect_pc,
        input  imem_wr_en, imem_wr_addr, imem_wr_data,
        output if_id, halted, fetch_count
    );

endinterface

// File: rtl/instr_mem.sv
// Instruction memory: synchronous write, combinational read (read-before-write).
module instr_mem #(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // Write port; contents survive reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, redirect, stall and halt handling.
module fetch_unit
    import fde_pkg::*;
#(
    parameter int unsigned    IMEM_DEPTH = 64,
    parameter logic [31:0]    RESET_PC   = 32'h0
) (
    input  logic       clock,
    input  logic       reset,
    fetch_unit_if.slave bus
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    if_id_t             if_id_q, if_id_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               halted_q;
    logic [INSTR_W-1:0] instr;

    instr_mem #(
        .DEPTH(IMEM_DEPTH)
    ) u_imem (
        .clock   (clock),
        .wr_en   (bus.imem_wr_en),
        .wr_addr (bus.imem_wr_addr),
        .wr_data (bus.imem_wr_data),
        .rd_addr (pc_q[AW-1:0]),
        .rd_data (instr)
    );

    // State, PC and pipeline registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            if_id_q  <= '{pc: 32'h0, instr: NOP_INSTR};
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            if_id_q  <= if_id_d;
            count_q  <= count_d;
            halted_q <= (state_d == HALTED);
        end
    end

    // Next-state and datapath selection; redirect outranks stall and halt
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if_id_d = if_id_q;
        count_d = count_q;
        unique case (state_q)
            RUN: begin
                if (bus.redirect) begin
                    if_id_d = '{pc: pc_q, instr: NOP_INSTR};
                    pc_d    = bus.redirect_pc;
                end else if (!bus.stall) begin
                    if_id_d = '{pc: pc_q, instr: instr};
                    count_d = (count_q == '1) ? count_q : count_q + COUNT_W'(1);
                    if (is_hlt(instr)) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            HALTED: begin
                if_id_d = '{pc: pc_q, instr: NOP_INSTR};
                if (bus.redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.if_id       = if_id_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written corner sequences.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h3800_0000;
    localparam logic [31:0] HLT = 32'h3400_0000;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [63:0] exp_if_id;
        logic        exp_halted;
        logic [15:0] exp_count;
    } vec_t;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;
    vec_t vecs[$];

    fetch_unit_if #(.IMEM_DEPTH(64)) bus ();

    fetch_unit #(
        .IMEM_DEPTH(64),
        .RESET_PC  (32'h0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic [31:0] pc, input logic [31:0] ins,
                                input logic h, input logic [15:0] cnt);
        vec_t v;
        v.stall      = s;
        v.redirect   = r;
        v.rpc        = rpc;
        v.exp_if_id  = {pc, ins};
        v.exp_halted = h;
        v.exp_count  = cnt;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [63:0] e_if_id,
                             input logic e_halted, input logic [15:0] e_count);
        check({name, ".if_id"}, bus.if_id, e_if_id);
        check({name, ".halted"}, 64'(bus.halted), 64'(e_halted));
        check({name, ".count"}, 64'(bus.fetch_count), 64'(e_count));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.stall        = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 32'h0;
        bus.imem_wr_en   = 1'b0;
        bus.imem_wr_addr = 6'd0;
        bus.imem_wr_data = 32'h0;

        // per-cycle vectors starting at the first edge after reset release
        vecs.push_back(mk(0, 0, 32'h00, 32'h00, 32'h0400_0000, 0, 16'd1));
        vecs.push_back(mk(0, 0, 32'h00, 32'h01, 32'h0800_0000, 0, 16'd2));
        vecs.push_back(mk(1, 0, 32'h00, 32'h01, 32'h0800_0000, 0, 16'd2));
        vecs.push_back(mk(1, 0, 32'h00, 32'h01, 32'h0800_0000, 0, 16'd2));
        vecs.push_back(mk(1, 0, 32'h00, 32'h01, 32'h0800_0000, 0, 16'd2));
        vecs.push_back(mk(0, 0, 32'h00, 32'h02, 32'h0C00_0000, 0, 16'd3));
        vecs.push_back(mk(0, 0, 32'h00, 32'h03, 32'h1000_0000, 0, 16'd4));
        vecs.push_back(mk(0, 0, 32'h00, 32'h04, 32'h1400_0000, 0, 16'd5));
        vecs.push_back(mk(1, 1, 32'h20, 32'h05, NOP,           0, 16'd5));
        vecs.push_back(mk(0, 0, 32'h00, 32'h20, 32'h8000_0020, 0, 16'd6));
        vecs.push_back(mk(0, 1, 32'h06, 32'h21, NOP,           0, 16'd6));
        vecs.push_back(mk(1, 0, 32'h00, 32'h21, NOP,           0, 16'd6));
        vecs.push_back(mk(0, 1, 32'h06, 32'h06, NOP,           0, 16'd6));
        vecs.push_back(mk(0, 0, 32'h00, 32'h06, HLT,           1, 16'd7));
        vecs.push_back(mk(1, 0, 32'h00, 32'h06, NOP,           1, 16'd7));
        vecs.push_back(mk(0, 0, 32'h00, 32'h06, NOP,           1, 16'd7));
        vecs.push_back(mk(0, 1, 32'h10, 32'h06, NOP,           0, 16'd7));
        vecs.push_back(mk(0, 0, 32'h00, 32'h10, 32'h8000_0010, 0, 16'd8));
        vecs.push_back(mk(0, 1, 32'h3F, 32'h11, NOP,           0, 16'd8));
        vecs.push_back(mk(0, 0, 32'h00, 32'h3F, 32'h8000_003F, 0, 16'd9));
        vecs.push_back(mk(0, 0, 32'h00, 32'h40, 32'h0400_0000, 0, 16'd10));
        vecs.push_back(mk(0, 0, 32'h00, 32'h41, 32'h0800_0000, 0, 16'd11));

        // reset state
        tick();
        check_all("reset", {32'h0, NOP}, 1'b0, 16'd0);

        // program load while held in reset
        for (int i = 0; i < 64; i++) begin
            bus.imem_wr_en   = 1'b1;
            bus.imem_wr_addr = 6'(i);
            if (i < 6)       bus.imem_wr_data = 32'(i + 1) << 26;
            else if (i == 6) bus.imem_wr_data = HLT;
            else             bus.imem_wr_data = 32'h8000_0000 | 32'(i);
            tick();
        end
        bus.imem_wr_en = 1'b0;
        check_all("held_reset", {32'h0, NOP}, 1'b0, 16'd0);
        reset = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            bus.stall       = vecs[k].stall;
            bus.redirect    = vecs[k].redirect;
            bus.redirect_pc = vecs[k].rpc;
            tick();
            check_all($sformatf("vec%0d", k), vecs[k].exp_if_id, vecs[k].exp_halted, vecs[k].exp_count);
        end
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;

        // write to the address being fetched: old data issued, new data seen on refetch
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0;
        tick();
        check_all("redir0", {32'h42, NOP}, 1'b0, 16'd11);
        bus.redirect = 1'b0;
        bus.imem_wr_en = 1'b1; bus.imem_wr_addr = 6'd0; bus.imem_wr_data = 32'hA800_0000;
        tick();
        check_all("rd_old", {32'h0, 32'h0400_0000}, 1'b0, 16'd12);
        bus.imem_wr_en = 1'b0;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0;
        tick();
        check_all("redir0b", {32'h1, NOP}, 1'b0, 16'd12);
        bus.redirect = 1'b0;
        tick();
        check_all("rd_new", {32'h0, 32'hA800_0000}, 1'b0, 16'd13);

        // write accepted while stalled
        bus.stall = 1'b1;
        bus.imem_wr_en = 1'b1; bus.imem_wr_addr = 6'd1; bus.imem_wr_data = 32'hA400_0001;
        tick();
        check_all("stall_wr", {32'h0, 32'hA800_0000}, 1'b0, 16'd13);
        bus.stall = 1'b0;
        bus.imem_wr_en = 1'b0;
        tick();
        check_all("stall_wr_rd", {32'h1, 32'hA400_0001}, 1'b0, 16'd14);

        // halt, then asynchronous reset between clock edges
        bus.redirect = 1'b1; bus.redirect_pc = 32'h6;
        tick();
        check_all("redir6", {32'h2, NOP}, 1'b0, 16'd14);
        bus.redirect = 1'b0;
        tick();
        check_all("halt2", {32'h6, HLT}, 1'b1, 16'd15);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_rst", {32'h0, NOP}, 1'b0, 16'd0);
        reset = 1'b0;
        tick();
        check_all("post_rst", {32'h0, 32'hA800_0000}, 1'b0, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
